// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, fixed-point helpers and load FSM encoding for the KxK conv engine
package conv_pkg;
  typedef enum logic {ST_IDLE, ST_LOAD} load_state_e;
  function automatic int data_width(input int ib, input int fb);
    return ib + fb;
  endfunction
  function automatic int sum_width(input int k, input int w);
    return 2 * w + $clog2(k * k);
  endfunction
  // Adding half an LSB before the arithmetic shift rounds half toward +inf
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] x, input int f);
    return (x + (64'sd1 <<< (f - 1))) >>> f;
  endfunction
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    return (x > mx) ? mx : (x < mn) ? mn : x;
  endfunction
endpackage

// File: rtl/conv_kernel_bank.sv
// conv_kernel_bank: serial shadow-bank loader with atomic swap into the active coefficient/bias bank
module conv_kernel_bank
  import conv_pkg::*;
#(
  parameter int W  = 12,
  parameter int KK = 9
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_kernel_load,
  input  logic [W-1:0]    i_kernel_word,
  input  logic            i_kernel_valid,
  output logic [KK*W-1:0] o_coef,
  output logic [W-1:0]    o_bias,
  output logic            o_kernel_ready,
  output logic            o_loading
);
  localparam int CW = $clog2(KK + 1);
  load_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr, swap, ready_q;
  logic [W-1:0] shadow_q [KK+1];
  logic [W-1:0] active_q [KK+1];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr = 1'b0;
    swap = 1'b0;
    if (i_kernel_load) begin
      state_d = ST_LOAD;
      cnt_d = '0;
    end else if (state_q == ST_LOAD && i_kernel_valid) begin
      wr = 1'b1;
      cnt_d = cnt_q + 1'b1;
      swap = (cnt_q == CW'(KK));
      state_d = swap ? ST_IDLE : ST_LOAD;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i <= KK; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (wr) shadow_q[cnt_q] <= i_kernel_word;
      // The bias word is still on the input when the swap fires, so it bypasses the shadow
      if (swap) begin
        for (int i = 0; i < KK; i++) active_q[i] <= shadow_q[i];
        active_q[KK] <= i_kernel_word;
        ready_q <= 1'b1;
      end
    end
  end
  for (genvar g = 0; g < KK; g++) begin : g_coef
    assign o_coef[g*W +: W] = active_q[g];
  end
  assign o_bias = active_q[KK];
  assign o_kernel_ready = ready_q;
  assign o_loading = (state_q == ST_LOAD);
endmodule

// File: rtl/conv_kxk_pipe.sv
// conv_kxk_pipe: 3-stage pipelined KxK signed fixed-point convolution with bias, rounding,
// saturation and optional ReLU; coefficients come from a double-buffered kernel bank.
module conv_kxk_pipe
  import conv_pkg::*;
#(
  parameter int INTEGER_BITS     = 8,
  parameter int FIXED_POINT_BITS = 4,
  parameter int KERNEL_SIZE      = 3,
  parameter int RELU_SUPPORT     = 1,
  localparam int W  = data_width(INTEGER_BITS, FIXED_POINT_BITS),
  localparam int KK = KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [KK*W-1:0] i_pixel_data,
  input  logic            i_pixel_data_valid,
  input  logic            i_kernel_load,
  input  logic [W-1:0]    i_kernel_word,
  input  logic            i_kernel_valid,
  input  logic            i_relu_en,
  output logic [W-1:0]    o_convolved_data,
  output logic            o_convolved_data_valid,
  output logic            o_kernel_ready,
  output logic            o_loading
);
  localparam int PW = 2 * W;
  localparam int SW = sum_width(KERNEL_SIZE, W);
  logic [KK*W-1:0] coef;
  logic [W-1:0] bias;
  logic signed [PW-1:0] prod_d [KK];
  logic signed [PW-1:0] prod_q [KK];
  logic signed [W-1:0] bias1_q, bias2_q;
  logic relu1_q, relu2_q, v1_q, v2_q, v3_q;
  logic signed [SW-1:0] sum_d, sum_q;
  logic signed [63:0] acc;
  logic [W-1:0] res, out_d, out_q;
  conv_kernel_bank #(.W(W), .KK(KK)) u_bank (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_kernel_load  (i_kernel_load),
    .i_kernel_word  (i_kernel_word),
    .i_kernel_valid (i_kernel_valid),
    .o_coef         (coef),
    .o_bias         (bias),
    .o_kernel_ready (o_kernel_ready),
    .o_loading      (o_loading)
  );
  always_comb begin
    for (int i = 0; i < KK; i++)
      prod_d[i] = PW'($signed(i_pixel_data[i*W +: W])) * PW'($signed(coef[i*W +: W]));
  end
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < KK; i++) sum_d = sum_d + SW'(prod_q[i]);
  end
  always_comb begin
    acc = 64'(sum_q) + (64'(bias2_q) <<< FIXED_POINT_BITS);
    res = W'(saturate(round_shift(acc, FIXED_POINT_BITS), W));
    out_d = (RELU_SUPPORT != 0 && relu2_q && res[W-1]) ? '0 : res;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      relu1_q <= 1'b0;
      relu2_q <= 1'b0;
      bias1_q <= '0;
      bias2_q <= '0;
      sum_q <= '0;
      out_q <= '0;
      for (int i = 0; i < KK; i++) prod_q[i] <= '0;
    end else begin
      v1_q <= i_pixel_data_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (i_pixel_data_valid) begin
        prod_q <= prod_d;
        bias1_q <= bias;
        relu1_q <= i_relu_en;
      end
      if (v1_q) begin
        sum_q <= sum_d;
        bias2_q <= bias1_q;
        relu2_q <= relu1_q;
      end
      if (v2_q) out_q <= out_d;
    end
  end
  assign o_convolved_data = out_q;
  assign o_convolved_data_valid = v3_q;
endmodule

// File: doc/conv_kxk_pipe.md
Name: conv_kxk_pipe

Overview:
- Parametrised, fully pipelined K×K signed fixed-point convolution engine. Next generation of the team's fixed 3×3 conv stage.
- Accepts one K×K pixel window per cycle. Computes the multiply-accumulate with a loadable bias, then rounds, saturates and optionally applies ReLU.
- Coefficients and bias load serially into a shadow bank while the active bank keeps convolving. The banks swap atomically when the load completes.
- Sits between the line-buffer/window generator and the activation/pooling stages.

Parameters:
- INTEGER_BITS, 8, integer bits of the signed two's-complement data format, sign bit included.
- FIXED_POINT_BITS, 4, fractional bits; must be ≥1.
- KERNEL_SIZE, 3, K; window is K×K; legal range 1..7.
- RELU_SUPPORT, 1, 1 = the i_relu_en path is present; 0 = ReLU logic is removed and i_relu_en is ignored.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_pixel_data  in  K*K*W  window; W=INTEGER_BITS+FIXED_POINT_BITS; tap i at bits [(i+1)*W-1 : i*W].
- i_pixel_data_valid  in  1  window valid this cycle.
- i_kernel_load  in  1  one-cycle pulse that starts or restarts a shadow-bank load.
- i_kernel_word  in  W  coefficient or bias word.
- i_kernel_valid  in  1  i_kernel_word valid this cycle.
- i_relu_en  in  1  clamp negative results to 0; sampled together with the window.
- o_convolved_data  out  W  result in the same Q format as the inputs.
- o_convolved_data_valid  out  1  result valid.
- o_kernel_ready  out  1  active bank holds a completely loaded kernel.
- o_loading  out  1  a shadow load is in progress.

Behaviour:
- Reset:
  - All outputs 0.
  - Both banks (all coefficients and bias) cleared to 0.
  - Pipeline valid bits cleared.
  - Load FSM goes to IDLE.
  - A reset mid-load aborts the load; the partially written shadow bank is discarded.
- Load FSM states IDLE and LOAD:
  - IDLE→LOAD on i_kernel_load. Word counter cleared, o_loading=1.
  - In LOAD, each i_kernel_valid writes i_kernel_word to shadow[count] and increments count.
  - Words 0..K*K-1 are coefficients for taps 0..K*K-1. Word K*K is the bias.
  - When word K*K is accepted: shadow copied to active (swap), o_kernel_ready=1, FSM→IDLE, o_loading=0.
  - i_kernel_load during LOAD restarts the load at count 0. That same cycle's i_kernel_valid word is ignored.
  - i_kernel_valid while in IDLE is ignored.
- Bank swap timing:
  - A window accepted in the same cycle as the final bias word uses the OLD bank.
  - A window accepted on the next cycle uses the NEW bank.
  - Bias is sampled into stage 1 and travels with its window, so every window sees one consistent coefficient/bias set.
- Pixels are accepted in every cycle that i_pixel_data_valid=1, in any FSM state. Before the first load the active bank is all zeros, so results are 0 with valid asserted.
- Pipeline: latency 3 cycles, throughput 1 window/cycle, no backpressure.
  - S1: K*K signed products, each 2W bits, Q(2I.2F), registered.
  - S2: sign-extended sum, width 2W+ceil(log2(K*K)), registered.
  - S3:
    - add bias << FIXED_POINT_BITS;
    - add 1<<(FIXED_POINT_BITS-1) (round half toward +∞);
    - arithmetic shift right by FIXED_POINT_BITS;
    - saturate to [-2^(W-1), 2^(W-1)-1];
    - if ReLU is enabled and the result is negative, output 0;
    - register the result.
- o_convolved_data_valid is i_pixel_data_valid delayed 3 cycles.
- o_convolved_data holds its last value when valid=0.

Decomposition:
- Shared package conv_pkg holds:
  - the data width function W;
  - the function sum_width(K, W);
  - the saturate and round helper functions;
  - the load FSM state encoding.
- One sub-module, conv_kernel_bank: shadow/active register banks, load FSM, word counter and swap. The arithmetic pipeline stays in conv_kxk_pipe.

Test Plan (W=12, FIXED_POINT_BITS=4, K=3):
1. Load 9×0x010 plus bias 0x000, then window all 0x010 → 0x090 (9.0) three cycles later, o_kernel_ready=1.
2. Kernel all 0xFF0 (−1.0), pixels all 0x010 → 0xF70 (−9.0) with i_relu_en=0; the same window with i_relu_en=1 → 0x000.
3. Kernel and pixels all 0x7FF → 0x7FF (positive saturation). Kernel 0x800 with pixels 0x7FF → 0x800 (negative saturation).
4. Rounding, single nonzero tap:
   - pixel 0x001 × coef 0x008 → 0x001 (+1/32 rounds up);
   - coef 0xFF8 → 0x000 (−1/32 rounds toward +∞);
   - bias 0x010 with a zero product → 0x010.
5. Stream windows every cycle while loading a new kernel:
   - outputs switch sets exactly for the window accepted the cycle after the bias word;
   - no bubble; valid stays continuous.
6. Reset after 5 words of a load → o_loading=0, o_kernel_ready=0, results 0. Also: i_kernel_load pulse mid-load, then 10 words → new kernel correct.
